// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the configurable UART receiver.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package uart_rx_pkg;

    localparam int OSR_DEFAULT = 16;

    typedef enum logic [1:0] {
        PAR_NONE  = 2'd0,
        PAR_EVEN  = 2'd1,
        PAR_ODD   = 2'd2,
        PAR_NONE3 = 2'd3
    } parity_t;

    // FSM state encoding kept as plain constants so older tools and
    // netlist-level debug see stable binary codes.
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_START   = 3'd1;
    localparam state_t ST_DATA    = 3'd2;
    localparam state_t ST_PARITY  = 3'd3;
    localparam state_t ST_STOP    = 3'd4;
    localparam state_t ST_WAIT_HI = 3'd5;

    // Out-of-range data-bit settings fall back to 8.
    function automatic logic [3:0] eff_dbits(input logic [3:0] dbits);
        return (dbits >= 4'd5 && dbits <= 4'd9) ? dbits : 4'd8;
    endfunction

    // XOR of the first dbits data bits, inverted for odd parity.
    // XOR with the received parity bit gives the error flag.
    function automatic logic par_calc(input logic [8:0] data,
                                      input logic [3:0] dbits,
                                      input logic       odd);
        logic p;
        p = odd;
        for (int i = 0; i < 9; i++) begin
            if (i < int'(dbits)) begin
                p = p ^ data[i];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_rx_sync_filter.sv
// Synchronises the async rx pad and optionally applies a 4-of-7 majority vote.
// Latency: SYNC_W+4 clocks on both edges, with or without the vote.
// Backpressure: none; free-running every clock.
module uart_rx_sync_filter #(
    parameter logic SYNC_STAGES   = 1'b1,
    parameter logic MAJORITY_VOTE = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic rx_i,
    output logic rx_o
);

    localparam int SYNC_W = SYNC_STAGES ? 3 : 2;

    logic [SYNC_W-1:0] sync_q;
    logic [6:0]        hist_q;
    logic [2:0]        ones;

    // Synchroniser chain feeding a 7-deep history; both reset to idle-high.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '1;
            hist_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_W-2:0], rx_i};
            hist_q <= {hist_q[5:0], sync_q[SYNC_W-1]};
        end
    end

    // Count ones in the history window for the vote.
    always_comb begin
        ones = 3'd0;
        for (int i = 0; i < 7; i++) begin
            ones = ones + {2'b00, hist_q[i]};
        end
    end

    // Bypass taps hist_q[3] so the delay matches the voted path exactly.
    assign rx_o = MAJORITY_VOTE ? (ones >= 3'd4) : hist_q[3];

endmodule

// File: rtl/uart_rx_cfg.sv
// UART receiver with runtime frame format (5..9 data, none/even/odd parity, 1/2 stop).
// Latency: result registered in the cycle after the last stop-bit sample tick.
// Backpressure: valid/ready; a frame completing while valid & !ready is dropped and flagged by overrun.
module uart_rx_cfg
    import uart_rx_pkg::*;
#(
    parameter int   OSR           = OSR_DEFAULT,
    parameter int   BAUD_W        = 16,
    parameter logic SYNC_STAGES   = 1'b1,
    parameter logic MAJORITY_VOTE = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rx_i,
    input  logic [BAUD_W-1:0] baud_div_i,
    input  logic [3:0]        cfg_dbits_i,
    input  logic [1:0]        cfg_parity_i,
    input  logic              cfg_stop2_i,
    output logic [8:0]        data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              parity_err_o,
    output logic              frame_err_o,
    output logic              break_o,
    output logic              overrun_o
);

    localparam int CNT_W = $clog2(OSR);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OSR / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OSR - 1);

    logic              rx_f;
    state_t            state_q;
    logic [BAUD_W-1:0] tick_cnt_q;
    logic [BAUD_W-1:0] baud_q;
    logic [CNT_W-1:0]  samp_cnt_q;
    logic [3:0]        bit_cnt_q;
    logic [3:0]        dbits_q;
    logic              par_en_q;
    logic              par_odd_q;
    logic              stop2_q;
    logic [8:0]        shreg_q;
    logic              perr_q;
    logic              ferr_q;
    logic              ones_q;
    parity_t           par_cfg;

    logic tick;
    logic samp;
    logic start_det;
    logic last_stop;
    logic deliver;

    uart_rx_sync_filter #(
        .SYNC_STAGES  (SYNC_STAGES),
        .MAJORITY_VOTE(MAJORITY_VOTE)
    ) u_filter (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .rx_i (rx_i),
        .rx_o (rx_f)
    );

    assign par_cfg = parity_t'(cfg_parity_i);

    // Strobes: oversample tick, bit-centre sample, start detect and frame completion.
    always_comb begin
        tick      = (tick_cnt_q == '0);
        samp      = tick && (samp_cnt_q == ((state_q == ST_START) ? HALF_LAST : FULL_LAST));
        start_det = (state_q == ST_IDLE) && !rx_f;
        last_stop = (bit_cnt_q == (stop2_q ? 4'd1 : 4'd0));
        deliver   = (state_q == ST_STOP) && samp && last_stop;
    end

    // Tick divider: reloads from the live divisor at start, then from the latched copy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tick_cnt_q <= '0;
        end else if (start_det) begin
            tick_cnt_q <= baud_div_i;
        end else if (tick) begin
            tick_cnt_q <= baud_q;
        end else begin
            tick_cnt_q <= tick_cnt_q - 1'b1;
        end
    end

    // Ticks since the last sample point; half a bit for start, a full bit afterwards.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            samp_cnt_q <= '0;
        end else if (start_det) begin
            samp_cnt_q <= '0;
        end else if (tick) begin
            samp_cnt_q <= samp ? '0 : samp_cnt_q + 1'b1;
        end
    end

    // Frame FSM: latch config at start, shift data, check parity and stop bits.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_cnt_q <= '0;
            dbits_q   <= 4'd8;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            stop2_q   <= 1'b0;
            shreg_q   <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ones_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!rx_f) begin
                        state_q   <= ST_START;
                        baud_q    <= baud_div_i;
                        dbits_q   <= eff_dbits(cfg_dbits_i);
                        par_en_q  <= (par_cfg == PAR_EVEN) || (par_cfg == PAR_ODD);
                        par_odd_q <= (par_cfg == PAR_ODD);
                        stop2_q   <= cfg_stop2_i;
                        bit_cnt_q <= '0;
                        shreg_q   <= '0;
                        perr_q    <= 1'b0;
                        ferr_q    <= 1'b0;
                        ones_q    <= 1'b0;
                    end
                end
                ST_START: begin
                    if (samp) begin
                        state_q <= rx_f ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (samp) begin
                        shreg_q[bit_cnt_q] <= rx_f;
                        ones_q             <= ones_q | rx_f;
                        if (bit_cnt_q == dbits_q - 4'd1) begin
                            bit_cnt_q <= '0;
                            state_q   <= par_en_q ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (samp) begin
                        perr_q  <= par_calc(shreg_q, dbits_q, par_odd_q) ^ rx_f;
                        ones_q  <= ones_q | rx_f;
                        state_q <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (samp) begin
                        ferr_q <= ferr_q | !rx_f;
                        ones_q <= ones_q | rx_f;
                        if (last_stop) begin
                            state_q <= rx_f ? ST_IDLE : ST_WAIT_HI;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end
                end
                ST_WAIT_HI: begin
                    if (rx_f) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Output register: load on completion when free or being drained, else flag overrun.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_o       <= '0;
            valid_o      <= 1'b0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
            break_o      <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            overrun_o <= 1'b0;
            if (deliver) begin
                if (!valid_o || ready_i) begin
                    data_o       <= shreg_q;
                    parity_err_o <= perr_q;
                    frame_err_o  <= ferr_q | !rx_f;
                    break_o      <= !(ones_q | rx_f);
                    valid_o      <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: directed scenarios plus randomized frames
// compared against a frame-level model of what each bit sequence should decode to.
module tb_uart_rx_cfg;

    localparam int OSR  = 16;
    localparam int BAUD = 3;
    localparam int BIT  = OSR * (BAUD + 1);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx = 1'b1;
    logic [15:0] baud_div = 16'(BAUD);
    logic [3:0]  cfg_dbits = 4'd8;
    logic [1:0]  cfg_parity = 2'd0;
    logic        cfg_stop2 = 1'b0;
    logic        ready = 1'b1;
    logic [8:0]  data;
    logic        valid, perr, ferr, brk, ovr;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ovr_cnt = 0;
    int start_cyc = 0;

    typedef struct {
        logic [8:0] d;
        logic       pe;
        logic       fe;
        logic       brk;
        int         cyc;
    } rec_t;

    rec_t got_q[$];
    rec_t exp_q[$];

    uart_rx_cfg #(.OSR(OSR), .BAUD_W(16), .SYNC_STAGES(1'b1), .MAJORITY_VOTE(1'b1)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .rx_i        (rx),
        .baud_div_i  (baud_div),
        .cfg_dbits_i (cfg_dbits),
        .cfg_parity_i(cfg_parity),
        .cfg_stop2_i (cfg_stop2),
        .data_o      (data),
        .valid_o     (valid),
        .ready_i     (ready),
        .parity_err_o(perr),
        .frame_err_o (ferr),
        .break_o     (brk),
        .overrun_o   (ovr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every accepted word and every overrun pulse, sampled mid-cycle.
    always @(negedge clk) begin : collect
        rec_t r;
        if (!rst && valid && ready) begin
            r.d = data; r.pe = perr; r.fe = ferr; r.brk = brk; r.cyc = cyc;
            got_q.push_back(r);
        end
        if (!rst && ovr) ovr_cnt++;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic line(input logic b, input int n);
        rx = b;
        wait_clks(n);
    endtask

    function automatic int nbits(input logic [3:0] d);
        return (d >= 4'd5 && d <= 4'd9) ? int'(d) : 8;
    endfunction

    // Drives one frame using the current cfg_* settings, then idles high for gap bits.
    task automatic send_frame(input logic [8:0] d, input logic pbit, input logic s0,
                              input logic s1, input int gap);
        int nb;
        nb = nbits(cfg_dbits);
        rx = 1'b0;
        start_cyc = cyc;
        wait_clks(BIT);
        for (int i = 0; i < nb; i++) line(d[i], BIT);
        if (cfg_parity == 2'd1 || cfg_parity == 2'd2) line(pbit, BIT);
        line(s0, BIT);
        if (cfg_stop2) line(s1, BIT);
        rx = 1'b1;
        if (gap > 0) wait_clks(gap * BIT);
    endtask

    // What the receiver should report for a given bit sequence, from the frame rules.
    function automatic rec_t model(input logic [3:0] dcfg, input logic [1:0] par, input logic st2,
                                   input logic [8:0] d, input logic pbit, input logic s0, input logic s1);
        rec_t r;
        int nb;
        logic [8:0] m;
        logic pen;
        nb = nbits(dcfg);
        m = 9'b0;
        for (int i = 0; i < nb; i++) m[i] = d[i];
        pen = (par == 2'd1) || (par == 2'd2);
        r.d = m;
        // even: total ones (data + parity bit) must be even; odd: must be odd
        r.pe = pen ? ((^m) ^ pbit ^ (par == 2'd2)) : 1'b0;
        r.fe = !s0 || (st2 && !s1);
        r.brk = (m == 9'd0) && (!pen || !pbit) && !s0 && (!st2 || !s1);
        r.cyc = 0;
        return r;
    endfunction

    task automatic wait_rec(input int budget, output logic ok);
        int n;
        n = 0;
        while (got_q.size() == 0 && n < budget) begin
            wait_clks(1);
            n++;
        end
        ok = (got_q.size() > 0);
    endtask

    task automatic set_cfg(input logic [3:0] d, input logic [1:0] p, input logic s2);
        cfg_dbits = d; cfg_parity = p; cfg_stop2 = s2;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        wait_clks(3);
        rst = 1'b0;
        wait_clks(1);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
        checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", ovr); end
        checks++; if (data !== 9'h000) begin errors++; $display("FAIL reset_data: got %h want 000", data); end
        checks++; if (perr !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b want 0", perr); end
        checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", ferr); end
        checks++; if (brk !== 1'b0) begin errors++; $display("FAIL reset_break: got %b want 0", brk); end
    endtask

    task automatic test_8n1;
        logic ok;
        rec_t r;
        int lat;
        // filter (3 sync + 4) + start register + half bit + 8 data + stop
        int lat_exp;
        lat_exp = 7 + 1 + BIT / 2 + 9 * BIT;
        got_q.delete();
        set_cfg(4'd8, 2'd0, 1'b0);
        ready = 1'b1;
        send_frame(9'h0A5, 1'b0, 1'b1, 1'b1, 1);
        wait_rec(2 * BIT, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL a5_delivered: got none want one frame");
        end else begin
            r = got_q.pop_front();
            lat = r.cyc - start_cyc;
            checks++; if (r.d !== 9'h0A5) begin errors++; $display("FAIL a5_data: got %h want 0a5", r.d); end
            checks++; if ({r.pe, r.fe, r.brk} !== 3'b000) begin errors++; $display("FAIL a5_errs: got %b want 000", {r.pe, r.fe, r.brk}); end
            checks++; if (lat < lat_exp - 4 || lat > lat_exp + 4) begin errors++; $display("FAIL a5_latency: got %0d want %0d +-4", lat, lat_exp); end
        end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL a5_valid_drop: got %b want 0", valid); end
    endtask

    task automatic test_parity;
        logic ok;
        rec_t r;
        for (int k = 0; k < 2; k++) begin
            got_q.delete();
            set_cfg(4'd7, (k == 0) ? 2'd1 : 2'd2, 1'b0);
            send_frame(9'h035, 1'b1, 1'b1, 1'b1, 1);
            wait_rec(2 * BIT, ok);
            checks++;
            if (!ok) begin
                errors++; $display("FAIL par%0d_delivered: got none want one frame", k);
            end else begin
                r = got_q.pop_front();
                checks++; if (r.d !== 9'h035) begin errors++; $display("FAIL par%0d_data: got %h want 035", k, r.d); end
                checks++; if (r.pe !== ((k == 0) ? 1'b1 : 1'b0)) begin errors++; $display("FAIL par%0d_err: got %b want %0d", k, r.pe, (k == 0) ? 1 : 0); end
                checks++; if ({r.fe, r.brk} !== 2'b00) begin errors++; $display("FAIL par%0d_other: got %b want 00", k, {r.fe, r.brk}); end
            end
        end
    endtask

    task automatic test_9n2_frame;
        logic ok;
        rec_t r;
        got_q.delete();
        set_cfg(4'd9, 2'd0, 1'b1);
        send_frame(9'h1FF, 1'b0, 1'b1, 1'b0, 1);
        wait_rec(2 * BIT, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL n92_delivered: got none want one frame");
        end else begin
            r = got_q.pop_front();
            checks++; if (r.d !== 9'h1FF) begin errors++; $display("FAIL n92_data: got %h want 1ff", r.d); end
            checks++; if (r.fe !== 1'b1) begin errors++; $display("FAIL n92_ferr: got %b want 1", r.fe); end
            checks++; if (r.brk !== 1'b0) begin errors++; $display("FAIL n92_break: got %b want 0", r.brk); end
        end
    endtask

    task automatic test_break;
        logic ok;
        rec_t r;
        got_q.delete();
        set_cfg(4'd8, 2'd0, 1'b0);
        line(1'b0, 20 * BIT);
        line(1'b1, 2 * BIT);
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL brk_count: got %0d want 1", got_q.size()); end
        if (got_q.size() > 0) begin
            r = got_q.pop_front();
            checks++; if ({r.d, r.fe, r.brk} !== {9'h000, 2'b11}) begin errors++; $display("FAIL brk_frame: got d=%h fe=%b brk=%b want d=000 fe=1 brk=1", r.d, r.fe, r.brk); end
        end
        got_q.delete();
        send_frame(9'h03C, 1'b0, 1'b1, 1'b1, 1);
        wait_rec(2 * BIT, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL brk_next: got none want frame 03c");
        end else begin
            r = got_q.pop_front();
            checks++; if ({r.d, r.pe, r.fe, r.brk} !== {9'h03C, 3'b000}) begin errors++; $display("FAIL brk_next_data: got d=%h errs=%b want d=03c errs=000", r.d, {r.pe, r.fe, r.brk}); end
        end
    endtask

    task automatic test_glitch;
        logic ok;
        rec_t r;
        got_q.delete();
        set_cfg(4'd8, 2'd0, 1'b0);
        line(1'b0, 3);
        line(1'b1, 12 * BIT);
        checks++; if (got_q.size() != 0 || valid !== 1'b0) begin errors++; $display("FAIL glitch3: got %0d frames valid=%b want 0 frames", got_q.size(), valid); end
        line(1'b0, 20);
        line(1'b1, 12 * BIT);
        checks++; if (got_q.size() != 0 || valid !== 1'b0) begin errors++; $display("FAIL false_start: got %0d frames valid=%b want 0 frames", got_q.size(), valid); end
        send_frame(9'h081, 1'b0, 1'b1, 1'b1, 1);
        wait_rec(2 * BIT, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL glitch_recover: got none want frame 081");
        end else begin
            r = got_q.pop_front();
            checks++; if (r.d !== 9'h081) begin errors++; $display("FAIL glitch_recover_data: got %h want 081", r.d); end
        end
    endtask

    task automatic test_overrun;
        logic ok;
        rec_t r;
        int ovr0;
        got_q.delete();
        set_cfg(4'd8, 2'd0, 1'b0);
        ready = 1'b0;
        ovr0 = ovr_cnt;
        send_frame(9'h011, 1'b0, 1'b1, 1'b1, 1);
        send_frame(9'h022, 1'b0, 1'b1, 1'b1, 2);
        checks++; if (ovr_cnt - ovr0 != 1) begin errors++; $display("FAIL ovr_pulses: got %0d want 1", ovr_cnt - ovr0); end
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b want 1", valid); end
        checks++; if (data !== 9'h011) begin errors++; $display("FAIL ovr_data: got %h want 011", data); end
        ready = 1'b1;
        wait_rec(20, ok);
        wait_clks(BIT);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL ovr_drain: got none want frame 011");
        end else begin
            r = got_q.pop_front();
            checks++; if (r.d !== 9'h011) begin errors++; $display("FAIL ovr_drain_data: got %h want 011", r.d); end
            checks++; if (got_q.size() != 0) begin errors++; $display("FAIL ovr_extra: got %0d extra frames want 0", got_q.size()); end
        end
    endtask

    task automatic test_reset_mid;
        logic ok;
        rec_t r;
        logic [7:0] d;
        d = 8'hF0;
        got_q.delete();
        set_cfg(4'd8, 2'd0, 1'b0);
        ready = 1'b1;
        line(1'b0, BIT);
        for (int i = 0; i < 5; i++) line(d[i], BIT);
        rx = 1'b1;
        wait_clks(BIT / 2);
        rst = 1'b1;
        wait_clks(2);
        rst = 1'b0;
        wait_clks(5 * BIT);
        checks++; if (valid !== 1'b0 || got_q.size() != 0) begin errors++; $display("FAIL rstmid_abort: got valid=%b frames=%0d want 0/0", valid, got_q.size()); end
        send_frame(9'h05A, 1'b0, 1'b1, 1'b1, 1);
        wait_rec(2 * BIT, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL rstmid_next: got none want frame 05a");
        end else begin
            r = got_q.pop_front();
            checks++; if ({r.d, r.pe, r.fe, r.brk} !== {9'h05A, 3'b000}) begin errors++; $display("FAIL rstmid_data: got d=%h errs=%b want d=05a errs=000", r.d, {r.pe, r.fe, r.brk}); end
        end
    endtask

    task automatic test_back_to_back;
        rec_t g, e;
        logic [8:0] d;
        logic pbit, s0, s1;
        int gap, n;
        got_q.delete();
        exp_q.delete();
        ready = 1'b1;
        for (int k = 0; k < 14; k++) begin
            cfg_dbits = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) cfg_dbits = 4'($urandom_range(5, 9));
            cfg_parity = 2'($urandom_range(0, 3));
            cfg_stop2 = 1'($urandom_range(0, 1));
            d = 9'($urandom);
            pbit = 1'($urandom_range(0, 1));
            s0 = ($urandom_range(0, 4) != 0);
            s1 = ($urandom_range(0, 4) != 0);
            if (k == 5) begin d = 9'h000; pbit = 1'b0; s0 = 1'b0; s1 = 1'b0; end
            gap = ((!cfg_stop2 && !s0) || (cfg_stop2 && !s1)) ? 1 : int'($urandom_range(0, 1));
            exp_q.push_back(model(cfg_dbits, cfg_parity, cfg_stop2, d, pbit, s0, s1));
            send_frame(d, pbit, s0, s1, gap);
        end
        wait_clks(2 * BIT);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            g = got_q[i];
            e = exp_q[i];
            checks++; if (g.d !== e.d) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", i, g.d, e.d); end
            checks++; if (g.pe !== e.pe) begin errors++; $display("FAIL b2b_perr[%0d]: got %b want %b", i, g.pe, e.pe); end
            checks++; if (g.fe !== e.fe) begin errors++; $display("FAIL b2b_ferr[%0d]: got %b want %b", i, g.fe, e.fe); end
            checks++; if (g.brk !== e.brk) begin errors++; $display("FAIL b2b_break[%0d]: got %b want %b", i, g.brk, e.brk); end
        end
    endtask

    initial begin
        test_reset();
        wait_clks(BIT);
        test_8n1();
        test_parity();
        test_9n2_frame();
        test_break();
        test_glitch();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
